// File: rtl/tmcu_gpio_pkg.sv
// Shared constants and edge-mode encoding for the GPIO input/interrupt block.
// Optional debounce is enabled by defining TMCU_GPIO_DEBOUNCE_EN.
package tmcu_gpio_pkg;

  localparam int TMCU_GPIO_WIDTH           = 32;
  localparam int TMCU_GPIO_SYNC_STAGES     = 2;
  localparam int TMCU_GPIO_DEBOUNCE_CYCLES = 16;

  // Register-side edge selection; bit 0 maps to irq_rise, bit 1 to irq_fall.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  function automatic logic edge_mode_rise(edge_mode_e mode);
    return mode[0];
  endfunction

  function automatic logic edge_mode_fall(edge_mode_e mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/tmcu_gpio_debounce.sv
// One GPIO pin: synchroniser chain plus, when TMCU_GPIO_DEBOUNCE_EN is
// defined, a consecutive-cycle debounce counter and stable-level flop.
module tmcu_gpio_debounce
  import tmcu_gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = TMCU_GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = TMCU_GPIO_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef TMCU_GPIO_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             st_q;
  logic             st_d;

  // Any cycle where the synchronised level matches the stable one restarts
  // the count, so only an uninterrupted run of DEBOUNCE_CYCLES is accepted.
  always_comb begin
    cnt_d = '0;
    st_d  = st_q;
    if (s != st_q) begin
      if (cnt_q == CNT_MAX) begin
        st_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      st_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign level_o = st_q;
`else
  logic [31:0] debounce_cfg_unused;
  assign debounce_cfg_unused = DEBOUNCE_CYCLES;

  assign level_o = s;
`endif

endmodule

// File: rtl/tmcu_gpio_irq.sv
// GPIO input view: per-pin sync/debounce, edge detect and sticky W1C status
// driving a single level interrupt. Debounce is built when TMCU_GPIO_DEBOUNCE_EN is defined.
module tmcu_gpio_irq
  import tmcu_gpio_pkg::*;
#(
  parameter int WIDTH           = TMCU_GPIO_WIDTH,
  parameter int SYNC_STAGES     = TMCU_GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = TMCU_GPIO_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_read,
  input  logic [WIDTH-1:0] irq_en,
  input  logic [WIDTH-1:0] irq_rise,
  input  logic [WIDTH-1:0] irq_fall,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] gpio_sync,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq_o
);

  logic [WIDTH-1:0] st;
  logic [WIDTH-1:0] prv_q;
  logic [WIDTH-1:0] prv_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] irq_status_q;
  logic [WIDTH-1:0] irq_status_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    tmcu_gpio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_pin (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (gpio_read[i]),
      .level_o (st[i])
    );
  end

  // A new edge in the same cycle as its clear strobe keeps the bit pending.
  always_comb begin
    prv_d        = st;
    rise         = st & ~prv_q;
    fall         = ~st & prv_q;
    set          = irq_en & ((rise & irq_rise) | (fall & irq_fall));
    irq_status_d = set | (irq_status_q & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prv_q        <= '0;
      irq_status_q <= '0;
    end else begin
      prv_q        <= prv_d;
      irq_status_q <= irq_status_d;
    end
  end

  assign gpio_sync  = st;
  assign irq_status = irq_status_q;
  assign irq_o      = |irq_status_q;

endmodule

// File: tb/tb_tmcu_gpio_irq.sv
// Directed bench for tmcu_gpio_irq; expected outputs are queued per cycle
// by the driver and checked by an independent negedge monitor.
module tb_tmcu_gpio_irq;

  localparam int W = 32;
`ifdef TMCU_GPIO_DEBOUNCE_EN
  localparam int L = 2 + 16;
`else
  localparam int L = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gpio_read;
  logic [W-1:0] irq_en;
  logic [W-1:0] irq_rise;
  logic [W-1:0] irq_fall;
  logic [W-1:0] irq_clr;
  logic [W-1:0] gpio_sync;
  logic [W-1:0] irq_status;
  logic         irq_o;

  tmcu_gpio_irq #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_read  (gpio_read),
    .irq_en     (irq_en),
    .irq_rise   (irq_rise),
    .irq_fall   (irq_fall),
    .irq_clr    (irq_clr),
    .gpio_sync  (gpio_sync),
    .irq_status (irq_status),
    .irq_o      (irq_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: entry is {irq_o, irq_status, gpio_sync} due at cycle cyc_q
  logic [2*W:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      logic [2*W:0] e;
      logic [2*W:0] a;
      string        nm;
      int           c;
      e  = exp_q.pop_front();
      c  = cyc_q.pop_front();
      nm = name_q.pop_front();
      a  = {irq_o, irq_status, gpio_sync};
      n_vec++;
      if (c != cyc || a !== e) begin
        n_err++;
        $display("FAIL %s @cyc %0d (due %0d): got sync=%h status=%h irq_o=%b, want sync=%h status=%h irq_o=%b",
                 nm, cyc, c, a[W-1:0], a[2*W-1:W], a[2*W], e[W-1:0], e[2*W-1:W], e[2*W]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_in(input int n, input logic [W-1:0] s, input logic [W-1:0] st,
                           input string nm);
    exp_q.push_back({|st, st, s});
    cyc_q.push_back(cyc + n);
    name_q.push_back(nm);
  endtask

  task automatic clr_pulse(input logic [W-1:0] m);
    irq_clr = m;
    tick(1);
    irq_clr = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    gpio_read = '0;
    irq_en    = '0;
    irq_rise  = '0;
    irq_fall  = '0;
    irq_clr   = '0;
    tick(2);
    expect_in(1, '0, '0, "rst_hold");
    tick(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) expect_in(i, '0, '0, "post_rst");
    tick(6);

    // pin 3 rising edge, then clear
    irq_en    = 32'h8;
    irq_rise  = 32'h8;
    gpio_read = 32'h8;
    expect_in(L - 1, '0, '0, "p3_presync");
    expect_in(L, 32'h8, '0, "p3_sync");
    expect_in(L + 1, 32'h8, 32'h8, "p3_status");
    tick(L + 2);
    expect_in(1, 32'h8, '0, "p3_clr");
    clr_pulse(32'h8);
    gpio_read = '0;
    irq_en    = '0;
    expect_in(L + 1, '0, '0, "p3_low");
    tick(L + 2);

    // pin 0: glitch filtering (debounce) or single-cycle pulse pass-through
    irq_en   = 32'h1;
    irq_rise = 32'h1;
`ifdef TMCU_GPIO_DEBOUNCE_EN
    expect_in(5, '0, '0, "glitch_mid");
    expect_in(L + 4, '0, '0, "glitch_end");
    gpio_read = 32'h1;
    tick(10);
    gpio_read = '0;
    tick(L + 6);
    gpio_read = 32'h1;
    expect_in(L - 1, '0, '0, "hold_pre");
    expect_in(L, 32'h1, '0, "hold_sync");
    expect_in(L + 1, 32'h1, 32'h1, "hold_status");
    tick(L + 2);
    expect_in(1, 32'h1, '0, "p0_clr");
    clr_pulse(32'h1);
`else
    expect_in(1, '0, '0, "pulse_pre");
    expect_in(2, 32'h1, '0, "pulse_sync");
    expect_in(3, '0, 32'h1, "pulse_status");
    gpio_read = 32'h1;
    tick(1);
    gpio_read = '0;
    tick(4);
    expect_in(1, '0, '0, "p0_clr");
    clr_pulse(32'h1);
`endif
    gpio_read = '0;
    irq_en    = '0;
    expect_in(L + 1, '0, '0, "p0_low");
    tick(L + 2);

    // pin 7 fall-only; pending bit survives irq_en going low
    irq_en    = 32'h80;
    irq_rise  = '0;
    irq_fall  = 32'h80;
    gpio_read = 32'h80;
    expect_in(L + 1, 32'h80, '0, "p7_rise_ignored");
    tick(L + 3);
    gpio_read = '0;
    expect_in(L, '0, '0, "p7_fall_sync");
    expect_in(L + 1, '0, 32'h80, "p7_fall_set");
    tick(L + 2);
    irq_en = '0;
    expect_in(2, '0, 32'h80, "p7_sticky_dis");
    tick(3);
    expect_in(1, '0, '0, "p7_clr");
    clr_pulse(32'h80);

    // pin 5: clear strobe lands in the same cycle as a new fall edge
    irq_en    = 32'h20;
    irq_rise  = 32'h20;
    irq_fall  = 32'h20;
    gpio_read = 32'h20;
    expect_in(L + 1, 32'h20, 32'h20, "p5_set");
    tick(L + 2);
    gpio_read = '0;
    tick(L);
    expect_in(1, '0, 32'h20, "p5_clr_vs_set");
    clr_pulse(32'h20);
    expect_in(1, '0, '0, "p5_clr");
    clr_pulse(32'h20);
    irq_en = '0;
    tick(2);

    // all pins, both edges
    irq_en    = '1;
    irq_rise  = '1;
    irq_fall  = '1;
    gpio_read = '1;
    expect_in(L - 1, '0, '0, "all_pre");
    expect_in(L + 1, '1, '1, "all_rise");
    tick(L + 2);
    expect_in(1, '1, '0, "all_clr");
    clr_pulse('1);
    gpio_read = '0;
    expect_in(L + 1, '0, '1, "all_fall");
    tick(L + 2);
    expect_in(1, '0, '0, "all_clr2");
    clr_pulse('1);

    // drain with a bounded wait, then report
    for (int g = 0; g < 100 && cyc_q.size() > 0; g++) tick(1);
    if (cyc_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", cyc_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tmcu_gpio_irq.md
Name: tmcu_gpio_irq

Overview:
Input-side companion to the GPIO pad driver. It takes the raw pin readback vector and produces a clean GPIO input view. Per-pin processing:
- Synchronises each pin into clk.
- Optionally debounces it.
- Detects rising and falling edges.
- Latches qualified edges into a sticky, write-1-to-clear interrupt status.
It sits between the pad driver's read vector and the MCU register/interrupt fabric and drives one level interrupt to the core.

Parameters:
WIDTH, 32, number of GPIO pins handled.
SYNC_STAGES, 2, flip-flops in each pin's synchroniser chain (legal range 2..4).
DEBOUNCE_CYCLES, 16, consecutive clk cycles a new level must hold before it is accepted (legal range >=2; counter width = $clog2(DEBOUNCE_CYCLES)+1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
gpio_read  input  WIDTH  raw, asynchronous pin levels from the GPIO pad driver
irq_en  input  WIDTH  per-pin interrupt enable
irq_rise  input  WIDTH  1 = a rising edge sets status
irq_fall  input  WIDTH  1 = a falling edge sets status
irq_clr  input  WIDTH  single-cycle write-1-to-clear strobe for irq_status
gpio_sync  output  WIDTH  synchronised (and debounced) pin levels
irq_status  output  WIDTH  sticky per-pin interrupt pending bits
irq_o  output  1  OR-reduction of irq_status

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - rst_n is asynchronous assert and synchronous release (release handled upstream).
  - Reset clears all synchroniser flops, stable levels, previous-level flops, debounce counters and irq_status to 0.
  - Outputs in reset: gpio_sync = 0, irq_status = 0, irq_o = 0.
- Synchroniser: gpio_read[i] passes through SYNC_STAGES flops. The last stage is s[i].
- Stable level st[i] (drives gpio_sync[i]):
  - Debounce disabled: st[i] = s[i], with no extra flop.
  - Debounce enabled: per-pin counter cnt[i].
    - If s[i] == st[i], then cnt[i] <= 0.
    - Otherwise cnt[i] <= cnt[i]+1.
    - When s[i] != st[i] and cnt[i] == DEBOUNCE_CYCLES-1, then st[i] <= s[i] and cnt[i] <= 0.
    - A glitch shorter than DEBOUNCE_CYCLES cycles never changes st[i], and it restarts the count.
- Edge detect:
  - prv[i] <= st[i] every cycle.
  - rise[i] = st[i] & ~prv[i]; fall[i] = ~st[i] & prv[i]. Both are single-cycle.
- Status:
  - set[i] = irq_en[i] & ((rise[i] & irq_rise[i]) | (fall[i] & irq_fall[i])).
  - Next irq_status[i] = set[i] | (irq_status[i] & ~irq_clr[i]).
  - If set and clear happen in the same cycle, set wins.
  - Status is sticky until cleared. Disabling irq_en does not clear pending bits.
- irq_o = |irq_status. It is combinational from the status register, with no added latency.
- Latency, with pin change settled before clk edge 0:
  - No debounce: gpio_sync at edge SYNC_STAGES; status at edge SYNC_STAGES+1.
  - Debounce: gpio_sync at edge SYNC_STAGES+DEBOUNCE_CYCLES; status one edge later.
- Pins high at reset release are seen as a rising edge once synchronised. They set status only if enabled for rise at that time.
- irq_rise and irq_fall both set: both edges qualify. Both clear: the pin never sets status.
- Reset mid-debounce discards the count. The level re-qualifies from 0.

Optional Feature:
TMCU_GPIO_DEBOUNCE_EN
- Defined: per-pin debounce counter as in Behaviour, using DEBOUNCE_CYCLES.
- Undefined: no counters are built, st = s, and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package tmcu_gpio_pkg holds:
  - TMCU_GPIO_WIDTH = 32
  - default SYNC_STAGES
  - default DEBOUNCE_CYCLES
  - the edge-mode enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH), used by register decode to drive irq_rise/irq_fall.
- One sub-module, tmcu_gpio_debounce: a single pin containing synchroniser, optional counter and stable flop. It is instantiated WIDTH times in a generate loop. Edge detect and status stay in the top.

Test Plan:
- Reset with gpio_read = 0: irq_status = 0, irq_o = 0, gpio_sync = 0. Hold the reset 5 cycles after release → outputs stay 0.
- Debounce off, irq_en[3] = 1, irq_rise[3] = 1, gpio_read[3] 0→1 → gpio_sync[3] = 1 at edge 2, irq_status = 0x8 at edge 3, irq_o = 1. Then irq_clr = 0x8 for one cycle → irq_status = 0, irq_o = 0.
- Debounce on, DEBOUNCE_CYCLES = 16, pin 0 pulses high for 10 cycles → gpio_sync[0] stays 0, no status. Pin held high 20 cycles → gpio_sync[0] = 1 at edge 18.
- irq_fall[7] = 1 only. Pin 7 goes 0→1 → no status. Pin 7 goes 1→0 → irq_status[7] = 1.
- Pending clear coincides with a new qualified edge on pin 5 → irq_status[5] stays 1.
- All 32 pins enabled for both edges, gpio_read toggles 0x0 → 0xFFFFFFFF → irq_status = 0xFFFFFFFF. Clear all, toggle back → irq_status = 0xFFFFFFFF again.
